// File: rtl/benes_cfg_loader.sv
// benes_cfg_loader: stages Benes switch words (module plane, then slot plane) in shadow registers and
// applies them atomically on commit. Define BENES_CFG_PARITY_EN to add per-word even-parity checking.
module benes_cfg_loader #(
  parameter int SWITCH_NUM = 16,
  parameter int STAGE_NUM  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cfg_start,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [SWITCH_NUM-1:0] i_cfg_word,
`ifdef BENES_CFG_PARITY_EN
  input  logic                  i_cfg_parity,
  output logic                  o_cfg_err,
`endif
  input  logic                  i_commit,
  output logic [SWITCH_NUM-1:0] o_module_select [0:STAGE_NUM-1],
  output logic [SWITCH_NUM-1:0] o_slot_select   [0:STAGE_NUM-1],
  output logic                  o_cfg_busy,
  output logic                  o_cfg_pend,
  output logic                  o_cfg_update
);

  localparam int CNT_W = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_MOD,
    ST_LOAD_SLOT,
    ST_PEND
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, busy_q, pend_q, update_q;
  logic             hs, word_ok, cnt_last, commit_fire, wr_mod, wr_slot;

`ifdef BENES_CFG_PARITY_EN
  logic err_q;
  assign word_ok   = ~(^{i_cfg_word, i_cfg_parity});
  assign o_cfg_err = err_q;
`else
  assign word_ok = 1'b1;
`endif

  // ready_q is high exactly while in a LOAD state, so it doubles as the state qualifier here
  assign hs          = i_cfg_valid & ready_q;
  assign cnt_last    = (cnt_q == CNT_LAST);
  assign commit_fire = i_commit & (state_q == ST_PEND);
  // A start in the same cycle discards the handshaken word
  assign wr_mod      = hs & ~i_cfg_start & word_ok & (state_q == ST_LOAD_MOD);
  assign wr_slot     = hs & ~i_cfg_start & word_ok & (state_q == ST_LOAD_SLOT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_cfg_start) begin
      state_d = ST_LOAD_MOD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_LOAD_MOD, ST_LOAD_SLOT: begin
          if (hs) begin
            if (!word_ok) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (cnt_last) begin
              state_d = (state_q == ST_LOAD_MOD) ? ST_LOAD_SLOT : ST_PEND;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_PEND: begin
          if (i_commit) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
      update_q <= 1'b0;
`ifdef BENES_CFG_PARITY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= (state_d == ST_LOAD_MOD) || (state_d == ST_LOAD_SLOT);
      busy_q   <= (state_d == ST_LOAD_MOD) || (state_d == ST_LOAD_SLOT);
      pend_q   <= (state_d == ST_PEND);
      update_q <= commit_fire;
`ifdef BENES_CFG_PARITY_EN
      if (i_cfg_start)         err_q <= 1'b0;
      else if (hs && !word_ok) err_q <= 1'b1;
`endif
    end
  end

  assign o_cfg_ready  = ready_q;
  assign o_cfg_busy   = busy_q;
  assign o_cfg_pend   = pend_q;
  assign o_cfg_update = update_q;

  // Per-stage shadow and active registers; active copies all stages on the commit edge only
  genvar gi;
  generate
    for (gi = 0; gi < STAGE_NUM; gi++) begin : g_stage
      logic [SWITCH_NUM-1:0] shadow_mod_q, shadow_slot_q;
      logic [SWITCH_NUM-1:0] active_mod_q, active_slot_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_mod_q  <= '0;
          shadow_slot_q <= '0;
          active_mod_q  <= '0;
          active_slot_q <= '0;
        end else begin
          if (wr_mod && (cnt_q == CNT_W'(gi)))  shadow_mod_q  <= i_cfg_word;
          if (wr_slot && (cnt_q == CNT_W'(gi))) shadow_slot_q <= i_cfg_word;
          if (commit_fire) begin
            active_mod_q  <= shadow_mod_q;
            active_slot_q <= shadow_slot_q;
          end
        end
      end

      assign o_module_select[gi] = active_mod_q;
      assign o_slot_select[gi]   = active_slot_q;
    end
  endgenerate

endmodule

// File: tb/tb_benes_cfg_loader.sv
// tb_benes_cfg_loader: table-driven and directed sequences plus randomized traffic checked
// against a handshake-count reference model of the config loader.
module tb_benes_cfg_loader;
  localparam int SW = 16;
  localparam int ST = 9;
`ifdef BENES_CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, i_cfg_start, i_cfg_valid, i_commit;
  logic [SW-1:0] i_cfg_word;
  logic          o_cfg_ready, o_cfg_busy, o_cfg_pend, o_cfg_update;
  logic [SW-1:0] o_module_select [0:ST-1];
  logic [SW-1:0] o_slot_select   [0:ST-1];
`ifdef BENES_CFG_PARITY_EN
  logic          i_cfg_parity, o_cfg_err;
`endif

  int total = 0;
  int bad   = 0;

  benes_cfg_loader #(.SWITCH_NUM(SW), .STAGE_NUM(ST)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_cfg_start    (i_cfg_start),
    .i_cfg_valid    (i_cfg_valid),
    .o_cfg_ready    (o_cfg_ready),
    .i_cfg_word     (i_cfg_word),
`ifdef BENES_CFG_PARITY_EN
    .i_cfg_parity   (i_cfg_parity),
    .o_cfg_err      (o_cfg_err),
`endif
    .i_commit       (i_commit),
    .o_module_select(o_module_select),
    .o_slot_select  (o_slot_select),
    .o_cfg_busy     (o_cfg_busy),
    .o_cfg_pend     (o_cfg_pend),
    .o_cfg_update   (o_cfg_update)
  );

  always #5 clk = ~clk;

  // Reference model: m_k counts accepted words of the current load (0..2*ST); word k goes to
  // plane k/ST, stage k%ST. m_mode: 0 idle, 1 loading, 2 pending commit.
  int            m_mode, m_k;
  bit            m_upd, m_err;
  logic [SW-1:0] m_sh  [2][ST];
  logic [SW-1:0] m_act [2][ST];
  logic [SW-1:0] t2w   [ST];

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_upd = 0; m_err = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < ST; i++) begin
        m_sh[p][i] = '0; m_act[p][i] = '0;
      end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, sample 1 time unit later
  task automatic step(input logic r, input logic st, input logic v, input logic [SW-1:0] w,
                      input logic cm, input logic pb);
    bit hs;
    rst = r; i_cfg_start = st; i_cfg_valid = v; i_cfg_word = w; i_commit = cm;
`ifdef BENES_CFG_PARITY_EN
    i_cfg_parity = (^w) ^ pb;
`endif
    @(posedge clk);
    hs = v && (m_mode == 1);
    if (r) model_reset();
    else begin
      m_upd = cm && (m_mode == 2);
      if (m_upd) m_act = m_sh;
      if (st) begin
        m_mode = 1; m_k = 0; m_err = 0;
      end else if (hs) begin
        if (PAR_EN && pb) begin
          m_mode = 0; m_k = 0; m_err = 1;
        end else begin
          m_sh[m_k / ST][m_k % ST] = w;
          m_k++;
          if (m_k == 2 * ST) begin m_mode = 2; m_k = 0; end
        end
      end else if (m_mode == 2 && cm) m_mode = 0;
    end
    #1;
  endtask

  task automatic idle(); step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0); endtask
  task automatic word(input logic [SW-1:0] w); step(1'b0, 1'b0, 1'b1, w, 1'b0, 1'b0); endtask

  task automatic chk1(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin bad++; $display("FAIL %s: got %b want %b", n, a, e); end
  endtask

  task automatic chk16(input string n, input logic [SW-1:0] a, input logic [SW-1:0] e);
    total++;
    if (a !== e) begin bad++; $display("FAIL %s: got %h want %h", n, a, e); end
  endtask

  task automatic chkw(input string n, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin bad++; $display("FAIL %s: got %h want %h", n, a, e); end
  endtask

  function automatic logic [255:0] dflat(input int p);
    logic [255:0] r = '0;
    for (int i = 0; i < ST; i++) r[i*SW +: SW] = (p != 0) ? o_slot_select[i] : o_module_select[i];
    return r;
  endfunction

  function automatic logic [255:0] mflat(input int p);
    logic [255:0] r = '0;
    for (int i = 0; i < ST; i++) r[i*SW +: SW] = m_act[p][i];
    return r;
  endfunction

  function automatic logic [255:0] rep(input logic [SW-1:0] w);
    logic [255:0] r = '0;
    for (int i = 0; i < ST; i++) r[i*SW +: SW] = w;
    return r;
  endfunction

  function automatic logic [255:0] t2flat();
    logic [255:0] r = '0;
    for (int i = 0; i < ST; i++) r[i*SW +: SW] = t2w[i];
    return r;
  endfunction

  typedef struct {
    logic          st;
    logic          v;
    logic [SW-1:0] w;
    logic          e_rdy;
    logic          e_busy;
    logic          e_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    t2w = '{16'hA300, 16'h00A8, 16'hE0E4, 16'h183C, 16'h1014, 16'h1014, 16'h2020, 16'h2810, 16'h2D00};
    rst = 1'b1; i_cfg_start = 0; i_cfg_valid = 0; i_cfg_word = '0; i_commit = 0;
`ifdef BENES_CFG_PARITY_EN
    i_cfg_parity = 0;
`endif
    model_reset();

    // T1 reset
    do_reset();
    chk1("t1_ready", o_cfg_ready, 1'b0);
    chk1("t1_busy", o_cfg_busy, 1'b0);
    chk1("t1_pend", o_cfg_pend, 1'b0);
    chk1("t1_update", o_cfg_update, 1'b0);
    chkw("t1_mod", dflat(0), '0);
    chkw("t1_slot", dflat(1), '0);
`ifdef BENES_CFG_PARITY_EN
    chk1("t1_err", o_cfg_err, 1'b0);
`endif

    // T2 table: start, then 18 words back to back
    tbl.push_back('{st: 1'b1, v: 1'b0, w: '0, e_rdy: 1'b1, e_busy: 1'b1, e_pend: 1'b0});
    for (int k = 0; k < 2 * ST; k++)
      tbl.push_back('{st: 1'b0, v: 1'b1, w: t2w[k % ST], e_rdy: (k < 2*ST-1), e_busy: (k < 2*ST-1),
                      e_pend: (k == 2*ST-1)});
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i].st, tbl[i].v, tbl[i].w, 1'b0, 1'b0);
      chk1($sformatf("t2_ready_%0d", i), o_cfg_ready, tbl[i].e_rdy);
      chk1($sformatf("t2_busy_%0d", i), o_cfg_busy, tbl[i].e_busy);
      chk1($sformatf("t2_pend_%0d", i), o_cfg_pend, tbl[i].e_pend);
      chk1($sformatf("t2_update_%0d", i), o_cfg_update, 1'b0);
    end
    chkw("t2_mod_before_commit", dflat(0), '0);
    chkw("t2_slot_before_commit", dflat(1), '0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("t2_update", o_cfg_update, 1'b1);
    chk16("t2_mod0", o_module_select[0], 16'hA300);
    chk16("t2_mod8", o_module_select[8], 16'h2D00);
    chk16("t2_slot2", o_slot_select[2], 16'hE0E4);
    chk1("t2_pend_after", o_cfg_pend, 1'b0);
    idle();
    chk1("t2_update_once", o_cfg_update, 1'b0);

    // T4 restart mid-load, then full 16'hFFFF load
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) word(16'h1230 + SW'(k));
    chkw("t4_mod_hold", dflat(0), t2flat());
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk1("t4_busy_restart", o_cfg_busy, 1'b1);
    for (int k = 0; k < 2 * ST; k++) word(16'hFFFF);
    chk1("t4_pend", o_cfg_pend, 1'b1);
    chkw("t4_slot_hold", dflat(1), t2flat());
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chkw("t4_mod_ffff", dflat(0), rep(16'hFFFF));
    chkw("t4_slot_ffff", dflat(1), rep(16'hFFFF));

    // T3 gapped valid after reset: one valid cycle in three
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 2 * ST - 1; k++) begin
      idle(); idle(); word(t2w[k % ST]);
    end
    chk1("t3_pend_17", o_cfg_pend, 1'b0);
    chk1("t3_busy_17", o_cfg_busy, 1'b1);
    idle(); idle(); word(t2w[ST-1]);
    chk1("t3_pend_18", o_cfg_pend, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("t3_update", o_cfg_update, 1'b1);
    chkw("t3_mod", dflat(0), t2flat());
    chkw("t3_slot", dflat(1), t2flat());

    // T5 commit during LOAD_MOD is ignored; start+commit together in PEND
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    word(16'h0100); word(16'h0101);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk1("t5_commit_in_load", o_cfg_update, 1'b0);
    chk1("t5_busy_in_load", o_cfg_busy, 1'b1);
    for (int k = 2; k < 2 * ST; k++) word(16'h0100 + SW'(k));
    chk1("t5_pend", o_cfg_pend, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk1("t5_update", o_cfg_update, 1'b1);
    chk1("t5_busy", o_cfg_busy, 1'b1);
    chk16("t5_mod0", o_module_select[0], 16'h0100);
    chk16("t5_slot8", o_slot_select[8], 16'h0111);
    for (int k = 0; k < 2 * ST; k++) word(16'h5A5A);
    chk1("t5_pend2", o_cfg_pend, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk1("t5_abandon_pend", o_cfg_pend, 1'b0);
    chk1("t5_abandon_upd", o_cfg_update, 1'b0);
    chk16("t5_abandon_mod0", o_module_select[0], 16'h0100);

`ifdef BENES_CFG_PARITY_EN
    // T6 bad parity on module word 3
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) word(16'h0F01 + SW'(k));
    step(1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b1);
    chk1("t6_err", o_cfg_err, 1'b1);
    chk1("t6_busy", o_cfg_busy, 1'b0);
    chk1("t6_ready", o_cfg_ready, 1'b0);
    chk1("t6_pend", o_cfg_pend, 1'b0);
    chkw("t6_mod", dflat(0), '0);
    idle();
    chk1("t6_err_sticky", o_cfg_err, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk1("t6_err_clear", o_cfg_err, 1'b0);
    chk1("t6_busy_restart", o_cfg_busy, 1'b1);
`endif

    // Randomized traffic against the reference model
    for (int c = 0; c < 4000; c++) begin
      logic r, st, v, cm, pb;
      r  = ($urandom % 500) == 0;
      st = ($urandom % 40) == 0;
      v  = ($urandom % 2) == 0;
      cm = ($urandom % 6) == 0;
      pb = ($urandom % 40) == 0;
      step(r, st, v, SW'($urandom), cm, pb);
      chk1($sformatf("rnd%0d_ready", c), o_cfg_ready, m_mode == 1);
      chk1($sformatf("rnd%0d_busy", c), o_cfg_busy, m_mode == 1);
      chk1($sformatf("rnd%0d_pend", c), o_cfg_pend, m_mode == 2);
      chk1($sformatf("rnd%0d_update", c), o_cfg_update, m_upd);
      chkw($sformatf("rnd%0d_mod", c), dflat(0), mflat(0));
      chkw($sformatf("rnd%0d_slot", c), dflat(1), mflat(1));
`ifdef BENES_CFG_PARITY_EN
      chk1($sformatf("rnd%0d_err", c), o_cfg_err, m_err);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
